// File: rtl/hopfield_core.sv
// hopfield_core: serialised Hopfield associative memory with Hebbian learning.
// Ports: learn/start valid-ready requests, clear, state/busy/done/converged/
// sweeps/pat_count status, and a combinational weight read port (rd_k, rd_m -> rd_w).
module hopfield_core #(
    parameter int N          = 25,
    parameter int W_BITS     = 4,
    parameter int MAX_SWEEPS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     learn_valid,
    input  logic [N-1:0]             learn_pattern,
    output logic                     learn_ready,
    input  logic                     clear,
    input  logic                     start_valid,
    input  logic [N-1:0]             start_pattern,
    output logic                     start_ready,
    output logic [N-1:0]             state,
    output logic                     busy,
    output logic                     done,
    output logic                     converged,
    output logic [7:0]               sweeps,
    output logic [7:0]               pat_count,
    input  logic [$clog2(N)-1:0]     rd_k,
    input  logic [$clog2(N)-1:0]     rd_m,
    output logic [W_BITS-1:0]        rd_w
);

    localparam int KW = $clog2(N);
    localparam int SW = W_BITS + KW + 1;
    localparam logic [KW-1:0] KMAX = KW'(N - 1);
    localparam logic signed [W_BITS-1:0] WMAX = {1'b0, {(W_BITS-1){1'b1}}};
    localparam logic signed [W_BITS-1:0] WMIN = {1'b1, {(W_BITS-1){1'b0}}};
    localparam logic signed [W_BITS-1:0] WONE = {{(W_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LEARN, RECALL, DONE} fsm_t;

    fsm_t fsm, fsm_nx;

    logic signed [W_BITS-1:0] w [N][N];

    logic [KW-1:0]        k, m;
    logic                 upd;
    logic [N-1:0]         pat;
    logic signed [SW-1:0] sum;
    logic                 changed;

    logic                     idle, do_clear, learn_acc, start_acc;
    logic                     last_km, sweep_end;
    logic signed [W_BITS-1:0] w_km, w_lrn;
    logic signed [SW-1:0]     w_ext, term, sum_acc;
    logic                     sum_pos, sum_neg, new_bit, any_chg;
    logic [7:0]               sweeps_inc;

    assign idle        = (fsm == IDLE);
    assign learn_ready = idle & ~clear;
    assign start_ready = idle & ~clear;
    assign do_clear    = idle & clear;
    assign learn_acc   = learn_valid & learn_ready;
    // learn outranks start: a start seen together with a learn waits
    assign start_acc   = start_valid & start_ready & ~learn_valid;

    assign busy = (fsm == LEARN) | (fsm == RECALL);
    assign done = (fsm == DONE);
    assign rd_w = w[rd_k][rd_m];

    assign w_km    = w[k][m];
    assign last_km = (k == KMAX) && (m == KMAX);

    // Hebbian step with saturation; the diagonal is pinned to zero
    always_comb begin
        w_lrn = w_km;
        if (k == m) begin
            w_lrn = '0;
        end else if (pat[k] == pat[m]) begin
            if (w_km != WMAX) w_lrn = w_km + WONE;
        end else begin
            if (w_km != WMIN) w_lrn = w_km - WONE;
        end
    end

    assign w_ext   = {{(SW-W_BITS){w_km[W_BITS-1]}}, w_km};
    assign term    = state[m] ? w_ext : -w_ext;
    assign sum_acc = sum + term;

    // zero field keeps the neuron's previous value
    assign sum_neg    = sum[SW-1];
    assign sum_pos    = ~sum[SW-1] & (|sum);
    assign new_bit    = sum_pos ? 1'b1 : (sum_neg ? 1'b0 : state[k]);
    assign any_chg    = changed | (new_bit ^ state[k]);
    assign sweeps_inc = sweeps + 8'd1;
    assign sweep_end  = (fsm == RECALL) && upd && (k == KMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm <= IDLE;
        else     fsm <= fsm_nx;
    end

    always_comb begin
        fsm_nx = fsm;
        unique case (fsm)
            IDLE: begin
                if (learn_acc)      fsm_nx = LEARN;
                else if (start_acc) fsm_nx = RECALL;
            end
            LEARN: begin
                if (last_km) fsm_nx = IDLE;
            end
            RECALL: begin
                if (sweep_end &&
                    (!any_chg || sweeps_inc == 8'(MAX_SWEEPS)))
                    fsm_nx = DONE;
            end
            DONE:    fsm_nx = IDLE;
            default: fsm_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k         <= '0;
            m         <= '0;
            upd       <= 1'b0;
            pat       <= '0;
            sum       <= '0;
            changed   <= 1'b0;
            state     <= '0;
            sweeps    <= '0;
            converged <= 1'b0;
            pat_count <= '0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (do_clear) begin
                        pat_count <= '0;
                    end else if (learn_acc) begin
                        pat <= learn_pattern;
                        k   <= '0;
                        m   <= '0;
                    end else if (start_acc) begin
                        state     <= start_pattern;
                        sweeps    <= '0;
                        converged <= 1'b0;
                        changed   <= 1'b0;
                        sum       <= '0;
                        upd       <= 1'b0;
                        k         <= '0;
                        m         <= '0;
                    end
                end
                LEARN: begin
                    if (m == KMAX) begin
                        m <= '0;
                        k <= k + 1'b1;
                    end else begin
                        m <= m + 1'b1;
                    end
                    if (last_km && pat_count != 8'hFF)
                        pat_count <= pat_count + 8'd1;
                end
                RECALL: begin
                    if (!upd) begin
                        sum <= sum_acc;
                        if (m == KMAX) begin
                            m   <= '0;
                            upd <= 1'b1;
                        end else begin
                            m <= m + 1'b1;
                        end
                    end else begin
                        state[k] <= new_bit;
                        sum      <= '0;
                        upd      <= 1'b0;
                        if (k == KMAX) begin
                            k       <= '0;
                            sweeps  <= sweeps_inc;
                            changed <= 1'b0;
                            if (!any_chg) converged <= 1'b1;
                        end else begin
                            k       <= k + 1'b1;
                            changed <= any_chg;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    w[i][j] <= '0;
        end else if (do_clear) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    w[i][j] <= '0;
        end else if (fsm == LEARN) begin
            w[k][m] <= w_lrn;
        end
    end

endmodule
